// File: rtl/scc_bus_initiator.sv
// Bus-side initiator for the SCC core: turns valid/ready register commands into
// timed wrreq/rdreq access windows and returns one response pulse per command.
module scc_bus_initiator #(
  parameter int ACCESS_CYCLES = 4,
  parameter int IDLE_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [14:0] cmd_address,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        wrreq,
  output logic        rdreq,
  output logic        wr_active,
  output logic        rd_active,
  output logic [14:0] a,
  output logic [7:0]  d,
  input  logic [7:0]  q
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  localparam logic [7:0] ACC_LOAD   = 8'(ACCESS_CYCLES - 1);
  localparam logic [7:0] REC_LOAD   = 8'(IDLE_CYCLES - 1);
  localparam bit         NO_RECOVER = (IDLE_CYCLES == 0);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [14:0] a_q, a_d;
  logic [7:0]  d_q, d_d;
  logic        wrreq_q, wrreq_d;
  logic        rdreq_q, rdreq_d;
  logic        wr_active_q, wr_active_d;
  logic        rd_active_q, rd_active_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        busy_q, busy_d;
  logic        accept_s;

  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign accept_s  = cmd_valid && cmd_ready;

  // Next-state and next-output decode for the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    a_d         = a_q;
    d_d         = d_q;
    wrreq_d     = 1'b0;
    rdreq_d     = 1'b0;
    wr_active_d = wr_active_q;
    rd_active_d = rd_active_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_data_d  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d     = ST_ACCESS;
          cnt_d       = ACC_LOAD;
          wr_d        = cmd_write;
          a_d         = cmd_address;
          d_d         = cmd_write ? cmd_data : 8'h00;
          wrreq_d     = cmd_write;
          rdreq_d     = !cmd_write;
          wr_active_d = cmd_write;
          rd_active_d = !cmd_write;
        end else begin
          wr_active_d = 1'b0;
          rd_active_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 8'd0) begin
          // Last window cycle: capture q at this edge, response shows next cycle.
          rsp_valid_d = 1'b1;
          rsp_write_d = wr_q;
          rsp_data_d  = wr_q ? 8'h00 : q;
          wr_active_d = 1'b0;
          rd_active_d = 1'b0;
          d_d         = 8'h00;
          if (NO_RECOVER) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end else begin
            state_d = ST_RECOVER;
            cnt_d   = REC_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RECOVER: begin
        wr_active_d = 1'b0;
        rd_active_d = 1'b0;
        d_d         = 8'h00;
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = 8'd0;
        wr_active_d = 1'b0;
        rd_active_d = 1'b0;
        d_d         = 8'h00;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output flops; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      wr_q        <= 1'b0;
      a_q         <= 15'h0000;
      d_q         <= 8'h00;
      wrreq_q     <= 1'b0;
      rdreq_q     <= 1'b0;
      wr_active_q <= 1'b0;
      rd_active_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      a_q         <= a_d;
      d_q         <= d_d;
      wrreq_q     <= wrreq_d;
      rdreq_q     <= rdreq_d;
      wr_active_q <= wr_active_d;
      rd_active_q <= rd_active_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign wrreq     = wrreq_q;
  assign rdreq     = rdreq_q;
  assign wr_active = wr_active_q;
  assign rd_active = rd_active_q;
  assign a         = a_q;
  assign d         = d_q;

endmodule

// File: tb/tb_scc_bus_initiator.sv
// Self-checking bench: default-parameter and minimum-timing initiators driven with
// random traffic, checked against a timeline model keyed on each command's accept cycle.
module tb_scc_bus_initiator;

  typedef struct {
    logic        wr;
    logic [14:0] addr;
    logic [7:0]  data;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  q_s;
  logic        cmd_valid_s   [2];
  logic        cmd_ready_s   [2];
  logic        cmd_write_s   [2];
  logic [14:0] cmd_address_s [2];
  logic [7:0]  cmd_data_s    [2];
  logic        rsp_valid_s   [2];
  logic        rsp_write_s   [2];
  logic [7:0]  rsp_data_s    [2];
  logic        busy_s        [2];
  logic        wrreq_s       [2];
  logic        rdreq_s       [2];
  logic        wr_active_s   [2];
  logic        rd_active_s   [2];
  logic [14:0] a_s           [2];
  logic [7:0]  d_s           [2];

  scc_bus_initiator dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid_s[0]), .cmd_ready(cmd_ready_s[0]), .cmd_write(cmd_write_s[0]),
    .cmd_address(cmd_address_s[0]), .cmd_data(cmd_data_s[0]),
    .rsp_valid(rsp_valid_s[0]), .rsp_write(rsp_write_s[0]), .rsp_data(rsp_data_s[0]),
    .busy(busy_s[0]), .wrreq(wrreq_s[0]), .rdreq(rdreq_s[0]),
    .wr_active(wr_active_s[0]), .rd_active(rd_active_s[0]),
    .a(a_s[0]), .d(d_s[0]), .q(q_s)
  );

  scc_bus_initiator #(.ACCESS_CYCLES(1), .IDLE_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid_s[1]), .cmd_ready(cmd_ready_s[1]), .cmd_write(cmd_write_s[1]),
    .cmd_address(cmd_address_s[1]), .cmd_data(cmd_data_s[1]),
    .rsp_valid(rsp_valid_s[1]), .rsp_write(rsp_write_s[1]), .rsp_data(rsp_data_s[1]),
    .busy(busy_s[1]), .wrreq(wrreq_s[1]), .rdreq(rdreq_s[1]),
    .wr_active(wr_active_s[1]), .rd_active(rd_active_s[1]),
    .a(a_s[1]), .d(d_s[1]), .q(q_s)
  );

  int tests = 0;
  int fails = 0;

  // Model: each instance remembers only its last accepted command and its accept cycle.
  int          n_c       [2];
  int          g_c       [2];
  int          acc_t     [2];
  logic        acc_wr    [2];
  logic [14:0] acc_addr  [2];
  logic [14:0] prev_addr [2];
  logic [7:0]  acc_data  [2];
  logic [7:0]  samp_q    [2];
  int          exp_rsp_n [2];
  int          got_rsp_n [2];
  cmd_t        cq0[$];
  bit          mid_pending = 1'b1;
  bit          mid_done    = 1'b0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int c);
    cmd_t cm;
    if (c < 3) begin
      reset = 1'b1;
    end else if (c >= 300 && mid_pending && acc_t[0] >= 0 && !acc_wr[0] && (c - acc_t[0]) == 2) begin
      reset       = 1'b1;
      mid_pending = 1'b0;
      mid_done    = 1'b1;
    end else begin
      reset = 1'b0;
    end
    q_s = (c < 40) ? 8'hC3 : 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      if (i == 0 && cq0.size() > 0) begin
        cm = cq0[0];
        cmd_valid_s[i] = 1'b1;
      end else begin
        cm.wr   = 1'($urandom_range(0, 1));
        cm.addr = 15'($urandom);
        cm.data = 8'($urandom);
        cmd_valid_s[i] = ($urandom_range(0, 2) != 0);
      end
      cmd_write_s[i]   = cm.wr;
      cmd_address_s[i] = cm.addr;
      cmd_data_s[i]    = cm.data;
    end
  endtask

  task automatic check_inst(input int i, input int c);
    int          k;
    int          n;
    int          g;
    bit          act;
    bit          req;
    bit          rsp;
    bit          rdy;
    logic [14:0] exp_a;
    string       sfx;
    n     = n_c[i];
    g     = g_c[i];
    k     = (acc_t[i] >= 0) ? (c - acc_t[i]) : -1;
    act   = (k >= 1) && (k <= n);
    req   = (k == 1);
    rsp   = (k == n + 1);
    rdy   = !reset && (acc_t[i] < 0 || k >= n + g + 1);
    exp_a = (k >= 1) ? acc_addr[i] : prev_addr[i];
    sfx   = $sformatf("[%0d]@%0d", i, c);
    chk_val({"cmd_ready", sfx}, 32'(cmd_ready_s[i]), 32'(rdy));
    chk_val({"busy", sfx},      32'(busy_s[i]),      32'((k >= 1) && (k <= n + g)));
    chk_val({"wrreq", sfx},     32'(wrreq_s[i]),     32'(req && acc_wr[i]));
    chk_val({"rdreq", sfx},     32'(rdreq_s[i]),     32'(req && !acc_wr[i]));
    chk_val({"wr_active", sfx}, 32'(wr_active_s[i]), 32'(act && acc_wr[i]));
    chk_val({"rd_active", sfx}, 32'(rd_active_s[i]), 32'(act && !acc_wr[i]));
    chk_val({"a", sfx},         32'(a_s[i]),         32'(exp_a));
    chk_val({"d", sfx},         32'(d_s[i]),         32'((act && acc_wr[i]) ? acc_data[i] : 8'h00));
    chk_val({"rsp_valid", sfx}, 32'(rsp_valid_s[i]), 32'(rsp));
    if (rsp) begin
      exp_rsp_n[i]++;
      chk_val({"rsp_write", sfx}, 32'(rsp_write_s[i]), 32'(acc_wr[i]));
      chk_val({"rsp_data", sfx},  32'(rsp_data_s[i]),  32'(acc_wr[i] ? 8'h00 : samp_q[i]));
    end
    if (rsp_valid_s[i] === 1'b1) got_rsp_n[i]++;
    if (k == n) samp_q[i] = q_s;
    if (reset) begin
      acc_t[i]     = -1;
      acc_wr[i]    = 1'b0;
      acc_addr[i]  = 15'h0000;
      prev_addr[i] = 15'h0000;
      acc_data[i]  = 8'h00;
    end else if (cmd_valid_s[i] && rdy) begin
      prev_addr[i] = exp_a;
      acc_t[i]     = c;
      acc_wr[i]    = cmd_write_s[i];
      acc_addr[i]  = cmd_address_s[i];
      acc_data[i]  = cmd_data_s[i];
      if (i == 0 && cq0.size() > 0) void'(cq0.pop_front());
    end
  endtask

  initial begin
    cmd_t cm;
    n_c[0] = 4;
    g_c[0] = 2;
    n_c[1] = 1;
    g_c[1] = 0;
    for (int i = 0; i < 2; i++) begin
      acc_t[i]     = -1;
      acc_wr[i]    = 1'b0;
      acc_addr[i]  = 15'h0000;
      prev_addr[i] = 15'h0000;
      acc_data[i]  = 8'h00;
      samp_q[i]    = 8'h00;
      exp_rsp_n[i] = 0;
      got_rsp_n[i] = 0;
    end
    cm.wr = 1'b1; cm.addr = 15'h38A0; cm.data = 8'h5A; cq0.push_back(cm);
    cm.wr = 1'b0; cm.addr = 15'h1880; cm.data = 8'hFF; cq0.push_back(cm);
    for (int j = 0; j < 4; j++) begin
      cm.wr   = 1'(j & 1);
      cm.addr = 15'($urandom);
      cm.data = 8'($urandom);
      cq0.push_back(cm);
    end
    reset = 1'b1;
    drive(0);
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      drive(c);
      @(negedge clk);
      if (c >= 1) begin
        check_inst(0, c);
        check_inst(1, c);
      end
    end
    chk_val("mid_reset_hit", 32'(mid_done), 32'd1);
    chk_val("rsp_count0", 32'(got_rsp_n[0]), 32'(exp_rsp_n[0]));
    chk_val("rsp_count1", 32'(got_rsp_n[1]), 32'(exp_rsp_n[1]));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
